// File: rtl/seq_detector_moore_n.sv
// Parametrised Moore sequence detector with a runtime-loadable N-bit pattern,
// optional overlap, enable-qualified input and a saturating match counter.
module seq_detector_moore_n #(
  parameter int unsigned N            = 4,
  parameter logic [N-1:0] PATTERN     = 4'b1101,
  parameter int unsigned OVERLAP      = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     x,
  input  logic                     load,
  input  logic [N-1:0]             pat_in,
  output logic                     y,
  output logic [$clog2(N+1)-1:0]   state,
  output logic [CNT_W-1:0]         count
);

  localparam int unsigned SW = $clog2(N + 1);
  localparam logic [SW-1:0]    Full   = SW'(N);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [N:0]       One    = (N + 1)'(1);

  logic [N-1:0]     pat_q;
  logic [SW-1:0]    state_q;
  logic             y_q;
  logic [CNT_W-1:0] count_q;

  logic [SW-1:0]    next_s;
  logic [N:0]       cand;
  logic [N:0]       mask;
  logic [N:0]       pref;
  int unsigned      s_eff;
  int unsigned      len;
  logic             ok;

  // Candidate is kept right-aligned: bit 0 is the newest bit x. The next state
  // is the longest k for which the low k candidate bits equal the top k of P.
  always_comb begin
    s_eff = int'(state_q);
    if (state_q == Full && OVERLAP == 0) begin
      s_eff = 0;
    end
    len    = s_eff + 1;
    cand   = (({1'b0, pat_q} >> (N - s_eff)) << 1) | {{N{1'b0}}, x};
    next_s = '0;
    mask   = '0;
    pref   = '0;
    ok     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      mask = (One << k) - One;
      pref = {1'b0, pat_q} >> (N - k);
      ok   = (k <= len) && ((cand & mask) == pref);
      if (ok) begin
        next_s = SW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= PATTERN;
      state_q <= '0;
      y_q     <= 1'b0;
      count_q <= '0;
    end else if (load) begin
      pat_q   <= pat_in;
      state_q <= '0;
      y_q     <= 1'b0;
      count_q <= '0;
    end else if (en) begin
      state_q <= next_s;
      y_q     <= (next_s == Full);
      if (next_s == Full && count_q != CntMax) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign y     = y_q;
  assign state = state_q;
  assign count = count_q;

endmodule

// File: tb/tb_seq_detector_moore_n.sv
// Scoreboard bench: three detector configurations driven by directed vectors;
// a negedge monitor pops expected responses and compares them to the DUT.
module tb_seq_detector_moore_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       ld  [3];
  logic       en  [3];
  logic       xb  [3];
  logic [3:0] pin [3];

  logic       y0, y1, y2;
  logic [2:0] s0, s1, s2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  // dut 0: 1101 overlapping; dut 1: 1101 non-overlapping; dut 2: 1111, 2-bit count
  seq_detector_moore_n #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(rst[0]), .en(en[0]), .x(xb[0]), .load(ld[0]), .pat_in(pin[0]),
    .y(y0), .state(s0), .count(c0)
  );
  seq_detector_moore_n #(.N(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(rst[1]), .en(en[1]), .x(xb[1]), .load(ld[1]), .pat_in(pin[1]),
    .y(y1), .state(s1), .count(c1)
  );
  seq_detector_moore_n #(.N(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(rst[2]), .en(en[2]), .x(xb[2]), .load(ld[2]), .pat_in(pin[2]),
    .y(y2), .state(s2), .count(c2)
  );

  typedef struct {
    int    d;
    int    ey;
    int    es;
    int    ec;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input string what, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   ay, as, ac;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.d)
        0:       begin ay = int'(y0); as = int'(s0); ac = int'(c0); end
        1:       begin ay = int'(y1); as = int'(s1); ac = int'(c1); end
        default: begin ay = int'(y2); as = int'(s2); ac = int'(c2); end
      endcase
      check(e.name, "y", ay, e.ey);
      check(e.name, "state", as, e.es);
      check(e.name, "count", ac, e.ec);
    end
  end

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; ld[i] = 1'b0; en[i] = 1'b0; xb[i] = 1'b0; pin[i] = 4'b0000;
    end
  endtask

  // Drive one cycle on dut d, then queue the expected post-edge outputs.
  task automatic step(input int d, input logic r, input logic l, input logic [3:0] p,
                      input logic e, input logic xi, input int es, input int ec,
                      input string name);
    exp_t item;
    idle_all();
    rst[d] = r; ld[d] = l; pin[d] = p; en[d] = e; xb[d] = xi;
    @(posedge clk);
    #1;
    item.d = d; item.es = es; item.ec = ec; item.ey = (es == 4) ? 1 : 0; item.name = name;
    sb.push_back(item);
    @(negedge clk);
  endtask

  task automatic bit_in(input int d, input logic xi, input int es, input int ec,
                        input string name);
    step(d, 1'b0, 1'b0, 4'b0000, 1'b1, xi, es, ec, name);
  endtask

  task automatic do_reset(input int d, input string name);
    step(d, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 0, 0, name);
  endtask

  initial begin
    idle_all();
    @(negedge clk);

    // Basic 1101 detection
    do_reset(0, "t1_rst");
    bit_in(0, 1, 1, 0, "t1_b1");
    bit_in(0, 1, 2, 0, "t1_b2");
    bit_in(0, 0, 3, 0, "t1_b3");
    bit_in(0, 1, 4, 1, "t1_b4");

    // Overlapping vs non-overlapping on 1101101
    do_reset(0, "t2o_rst");
    bit_in(0, 1, 1, 0, "t2o_b1");
    bit_in(0, 1, 2, 0, "t2o_b2");
    bit_in(0, 0, 3, 0, "t2o_b3");
    bit_in(0, 1, 4, 1, "t2o_b4");
    bit_in(0, 1, 2, 1, "t2o_b5");
    bit_in(0, 0, 3, 1, "t2o_b6");
    bit_in(0, 1, 4, 2, "t2o_b7");
    do_reset(1, "t2n_rst");
    bit_in(1, 1, 1, 0, "t2n_b1");
    bit_in(1, 1, 2, 0, "t2n_b2");
    bit_in(1, 0, 3, 0, "t2n_b3");
    bit_in(1, 1, 4, 1, "t2n_b4");
    bit_in(1, 1, 1, 1, "t2n_b5");
    bit_in(1, 0, 0, 1, "t2n_b6");
    bit_in(1, 1, 1, 1, "t2n_b7");

    // Failure paths: 111101 and 11001101
    do_reset(0, "t3a_rst");
    bit_in(0, 1, 1, 0, "t3a_b1");
    bit_in(0, 1, 2, 0, "t3a_b2");
    bit_in(0, 1, 2, 0, "t3a_b3");
    bit_in(0, 1, 2, 0, "t3a_b4");
    bit_in(0, 0, 3, 0, "t3a_b5");
    bit_in(0, 1, 4, 1, "t3a_b6");
    do_reset(0, "t3b_rst");
    bit_in(0, 1, 1, 0, "t3b_b1");
    bit_in(0, 1, 2, 0, "t3b_b2");
    bit_in(0, 0, 3, 0, "t3b_b3");
    bit_in(0, 0, 0, 0, "t3b_b4");
    bit_in(0, 1, 1, 0, "t3b_b5");
    bit_in(0, 1, 2, 0, "t3b_b6");
    bit_in(0, 0, 3, 0, "t3b_b7");
    bit_in(0, 1, 4, 1, "t3b_b8");

    // Enable gaps and mid-sequence reset
    do_reset(0, "t4_rst");
    bit_in(0, 1, 1, 0, "t4_b1");
    step(0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1, 0, "t4_gap");
    bit_in(0, 1, 2, 0, "t4_b2");
    bit_in(0, 0, 3, 0, "t4_b3");
    bit_in(0, 1, 4, 1, "t4_b4");
    step(0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4, 1, "t4_hold");
    bit_in(0, 1, 2, 1, "t4_c1");
    bit_in(0, 1, 2, 1, "t4_c2");
    bit_in(0, 0, 3, 1, "t4_c3");
    do_reset(0, "t4_midrst");
    bit_in(0, 1, 1, 0, "t4_after");

    // Runtime load of 0110, then load+en in the same cycle
    do_reset(0, "t5_rst");
    bit_in(0, 1, 1, 0, "t5_p1");
    bit_in(0, 1, 2, 0, "t5_p2");
    bit_in(0, 0, 3, 0, "t5_p3");
    step(0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 0, 0, "t5_load");
    bit_in(0, 0, 1, 0, "t5_b1");
    bit_in(0, 1, 2, 0, "t5_b2");
    bit_in(0, 1, 3, 0, "t5_b3");
    bit_in(0, 0, 4, 1, "t5_b4");
    bit_in(0, 1, 2, 1, "t5_b5");
    bit_in(0, 1, 3, 1, "t5_b6");
    bit_in(0, 0, 4, 2, "t5_b7");
    step(0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0, 0, 0, "t5_loaden");
    bit_in(0, 0, 1, 0, "t5_post");

    // Saturation with 1111, 2-bit counter
    do_reset(2, "t6_rst");
    bit_in(2, 1, 1, 0, "t6_b1");
    bit_in(2, 1, 2, 0, "t6_b2");
    bit_in(2, 1, 3, 0, "t6_b3");
    bit_in(2, 1, 4, 1, "t6_b4");
    bit_in(2, 1, 4, 2, "t6_b5");
    bit_in(2, 1, 4, 3, "t6_b6");
    bit_in(2, 1, 4, 3, "t6_b7");
    bit_in(2, 1, 4, 3, "t6_b8");
    bit_in(2, 0, 0, 3, "t6_b9");

    idle_all();
    repeat (2) @(negedge clk);
    check("scoreboard", "leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
